// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and word-level types used by the fetch stage.
package y86_pkg;

    localparam int WORD_W = 64;
    typedef logic [WORD_W-1:0] word_t;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic [1:0] {
        STAT_AOK = 2'd0,
        STAT_HLT = 2'd1,
        STAT_ADR = 2'd2,
        STAT_INS = 2'd3
    } stat_t;

    typedef struct packed {
        stat_t      stat;
        logic [3:0] icode;
        logic [3:0] ifun;
        logic [3:0] ra;
        logic [3:0] rb;
        word_t      valc;
        word_t      valp;
    } d_reg_t;

    // Value the decode register holds after reset or when a bubble is injected.
    localparam d_reg_t D_BUBBLE = '{
        stat:  STAT_AOK,
        icode: I_NOP,
        ifun:  4'h0,
        ra:    RNONE,
        rb:    RNONE,
        valc:  '0,
        valp:  '0
    };

    function automatic logic icode_valid(input logic [3:0] icode);
        return icode <= I_POPQ;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bus between the fetch stage and its surroundings: hazard controls, feedback,
// instruction memory port and the decode pipeline register outputs.
interface fetch_stage_if;
    import y86_pkg::*;

    logic        F_stall;
    logic        D_stall;
    logic        D_bubble;
    logic [3:0]  M_icode;
    logic        M_cnd;
    word_t       M_valA;
    logic [3:0]  W_icode;
    word_t       W_valM;
    logic [79:0] imem_instr;
    logic        imem_error;

    word_t       f_pc;
    word_t       F_predPC;
    logic [1:0]  D_stat;
    logic [3:0]  D_icode;
    logic [3:0]  D_ifun;
    logic [3:0]  D_rA;
    logic [3:0]  D_rB;
    word_t       D_valC;
    word_t       D_valP;

    modport master (
        output F_stall, D_stall, D_bubble,
        output M_icode, M_cnd, M_valA, W_icode, W_valM,
        output imem_instr, imem_error,
        input  f_pc, F_predPC,
        input  D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP
    );

    modport slave (
        input  F_stall, D_stall, D_bubble,
        input  M_icode, M_cnd, M_valA, W_icode, W_valM,
        input  imem_instr, imem_error,
        output f_pc, F_predPC,
        output D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP
    );

endinterface

// File: rtl/instr_split.sv
// Splits the ten fetched bytes into instruction fields and computes valC/valP.
module instr_split
    import y86_pkg::*;
(
    input  logic [79:0] instr_i,
    input  logic        imem_error_i,
    input  word_t       pc_i,
    output logic [3:0]  icode_o,
    output logic [3:0]  ifun_o,
    output logic [3:0]  ra_o,
    output logic [3:0]  rb_o,
    output word_t       valc_o,
    output word_t       valp_o,
    output logic        instr_valid_o
);

    logic [7:0] byte0;
    logic [7:0] byte1;
    logic       need_regids;
    logic       need_valc;

    assign byte0 = instr_i[7:0];
    assign byte1 = instr_i[15:8];

    // A bad fetch address is turned into a nop so nothing downstream acts on it.
    assign icode_o = imem_error_i ? I_NOP : byte0[7:4];
    assign ifun_o  = imem_error_i ? 4'h0  : byte0[3:0];

    assign instr_valid_o = icode_valid(icode_o);

    always_comb begin
        need_regids = 1'b0;
        need_valc   = 1'b0;
        case (icode_o)
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: need_regids = 1'b1;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
                need_regids = 1'b1;
                need_valc   = 1'b1;
            end
            I_JXX, I_CALL: need_valc = 1'b1;
            default: ;
        endcase
    end

    assign ra_o = need_regids ? byte1[7:4] : RNONE;
    assign rb_o = need_regids ? byte1[3:0] : RNONE;

    always_comb begin
        valc_o = '0;
        if (need_valc) begin
            valc_o = need_regids ? instr_i[79:16] : instr_i[71:8];
        end
    end

    assign valp_o = pc_i + 64'd1 + {63'd0, need_regids} + {60'd0, need_valc, 3'b000};

endmodule

// File: rtl/fetch_stage.sv
// Y86-64 fetch stage: PC selection, instruction split, PC prediction and
// the F (predicted PC) and D pipeline registers.
module fetch_stage
    import y86_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    fetch_stage_if.slave bus
);

    word_t      f_pc;
    logic [3:0] f_icode;
    logic [3:0] f_ifun;
    logic [3:0] f_ra;
    logic [3:0] f_rb;
    word_t      f_valc;
    word_t      f_valp;
    logic       f_instr_valid;
    stat_t      f_stat;
    word_t      f_predpc;

    word_t      pred_pc_q, pred_pc_d;
    d_reg_t     d_q, d_d;
    d_reg_t     d_fetch;

    // Misprediction from memory wins over the return address from write-back.
    always_comb begin
        f_pc = pred_pc_q;
        if (bus.M_icode == I_JXX && !bus.M_cnd) begin
            f_pc = bus.M_valA;
        end else if (bus.W_icode == I_RET) begin
            f_pc = bus.W_valM;
        end
    end

    instr_split u_split (
        .instr_i       (bus.imem_instr),
        .imem_error_i  (bus.imem_error),
        .pc_i          (f_pc),
        .icode_o       (f_icode),
        .ifun_o        (f_ifun),
        .ra_o          (f_ra),
        .rb_o          (f_rb),
        .valc_o        (f_valc),
        .valp_o        (f_valp),
        .instr_valid_o (f_instr_valid)
    );

    always_comb begin
        f_stat = STAT_AOK;
        if (bus.imem_error) begin
            f_stat = STAT_ADR;
        end else if (!f_instr_valid) begin
            f_stat = STAT_INS;
        end else if (f_icode == I_HALT) begin
            f_stat = STAT_HLT;
        end
    end

    assign f_predpc = (f_icode == I_JXX || f_icode == I_CALL) ? f_valc : f_valp;

    assign d_fetch = '{
        stat:  f_stat,
        icode: f_icode,
        ifun:  f_ifun,
        ra:    f_ra,
        rb:    f_rb,
        valc:  f_valc,
        valp:  f_valp
    };

    assign pred_pc_d = bus.F_stall ? pred_pc_q : f_predpc;

    // Stall outranks bubble so a held instruction is never squashed by accident.
    always_comb begin
        d_d = d_fetch;
        if (bus.D_stall) begin
            d_d = d_q;
        end else if (bus.D_bubble) begin
            d_d = D_BUBBLE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pred_pc_q <= '0;
            d_q       <= D_BUBBLE;
        end else begin
            pred_pc_q <= pred_pc_d;
            d_q       <= d_d;
        end
    end

    assign bus.f_pc     = f_pc;
    assign bus.F_predPC = pred_pc_q;
    assign bus.D_stat   = d_q.stat;
    assign bus.D_icode  = d_q.icode;
    assign bus.D_ifun   = d_q.ifun;
    assign bus.D_rA     = d_q.ra;
    assign bus.D_rB     = d_q.rb;
    assign bus.D_valC   = d_q.valc;
    assign bus.D_valP   = d_q.valp;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed vector bench for fetch_stage: PC select, field split, prediction,
// stall/bubble handling and reset.
module tb_fetch_stage;

    logic clk;
    logic rst;

    fetch_stage_if bus ();

    fetch_stage dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        fs;
        logic        ds;
        logic        db;
        logic [3:0]  m_icode;
        logic        m_cnd;
        logic [63:0] m_vala;
        logic [3:0]  w_icode;
        logic [63:0] w_valm;
        logic [79:0] instr;
        logic        err;
        logic [63:0] e_fpc;
        logic [63:0] e_pred;
        logic [1:0]  e_stat;
        logic [3:0]  e_icode;
        logic [3:0]  e_ifun;
        logic [3:0]  e_ra;
        logic [3:0]  e_rb;
        logic [63:0] e_valc;
        logic [63:0] e_valp;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp;
    int   n_bad;

    function automatic logic [79:0] i_rv(input logic [7:0] b0, input logic [7:0] b1, input logic [63:0] v);
        return {v, b1, b0};
    endfunction

    function automatic logic [79:0] i_v(input logic [7:0] b0, input logic [63:0] v);
        return {8'h00, v, b0};
    endfunction

    function automatic logic [79:0] i_rr(input logic [7:0] b0, input logic [7:0] b1);
        return {64'h0, b1, b0};
    endfunction

    function automatic logic [79:0] i_1(input logic [7:0] b0);
        return {72'h0, b0};
    endfunction

    task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (vec %0d): got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic chk_d(input int idx, input logic [1:0] st, input logic [3:0] ic, input logic [3:0] fn,
                         input logic [3:0] ra, input logic [3:0] rb, input logic [63:0] vc, input logic [63:0] vp);
        chk("D_stat",  idx, {62'd0, bus.D_stat},  {62'd0, st});
        chk("D_icode", idx, {60'd0, bus.D_icode}, {60'd0, ic});
        chk("D_ifun",  idx, {60'd0, bus.D_ifun},  {60'd0, fn});
        chk("D_rA",    idx, {60'd0, bus.D_rA},    {60'd0, ra});
        chk("D_rB",    idx, {60'd0, bus.D_rB},    {60'd0, rb});
        chk("D_valC",  idx, bus.D_valC, vc);
        chk("D_valP",  idx, bus.D_valP, vp);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;

        //            rst  fs   ds   db   M_icode M_cnd M_valA      W_icode W_valM     instr                                  err   f_pc        predPC     stat  icode ifun  rA    rB    valC                     valP
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0, 4'd0, 1'b0, 64'h0,     4'd0, 64'h0,      i_rv(8'h30,8'hF3,64'd8),              1'b0, 64'h0,      64'hA,     2'd0, 4'h3, 4'h0, 4'hF, 4'h3, 64'd8,                   64'hA});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0, 4'd0, 1'b0, 64'h0,     4'd0, 64'h0,      i_1(8'h10),                           1'b0, 64'hA,      64'hB,     2'd0, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0,                   64'hB});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0, 4'd0, 1'b0, 64'h0,     4'd0, 64'h0,      i_rr(8'h60,8'h23),                    1'b0, 64'hB,      64'hD,     2'd0, 4'h6, 4'h0, 4'h2, 4'h3, 64'd0,                   64'hD});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0, 4'd0, 1'b0, 64'h0,     4'd0, 64'h0,      i_v(8'h80,64'h20),                    1'b0, 64'hD,      64'h20,    2'd0, 4'h8, 4'h0, 4'hF, 4'hF, 64'h20,                  64'h16});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0, 4'd0, 1'b0, 64'h0,     4'd0, 64'h0,      i_v(8'h74,64'h100),                   1'b0, 64'h20,     64'h100,   2'd0, 4'h7, 4'h4, 4'hF, 4'hF, 64'h100,                 64'h29});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0, 4'd7, 1'b0, 64'h29,    4'd0, 64'h0,      i_rv(8'h40,8'h45,64'h1122334455667788),1'b0, 64'h29,     64'h33,    2'd0, 4'h4, 4'h0, 4'h4, 4'h5, 64'h1122334455667788,    64'h33});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0, 4'd7, 1'b1, 64'h999,   4'd0, 64'h0,      i_1(8'h90),                           1'b0, 64'h33,     64'h34,    2'd0, 4'h9, 4'h0, 4'hF, 4'hF, 64'd0,                   64'h34});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0, 4'd0, 1'b0, 64'h0,     4'd9, 64'h1234,   i_rv(8'h50,8'h12,64'd7),              1'b0, 64'h1234,   64'h123E,  2'd0, 4'h5, 4'h0, 4'h1, 4'h2, 64'd7,                   64'h123E});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0, 4'd7, 1'b0, 64'h300,   4'd9, 64'h5000,   i_rr(8'hA0,8'h3F),                    1'b0, 64'h300,    64'h302,   2'd0, 4'hA, 4'h0, 4'h3, 4'hF, 64'd0,                   64'h302});
        vecs.push_back('{1'b0,1'b1,1'b1,1'b0, 4'd0, 1'b0, 64'h0,     4'd0, 64'h0,      i_1(8'h00),                           1'b0, 64'h302,    64'h302,   2'd0, 4'hA, 4'h0, 4'h3, 4'hF, 64'd0,                   64'h302});
        vecs.push_back('{1'b0,1'b1,1'b1,1'b0, 4'd0, 1'b0, 64'h0,     4'd0, 64'h0,      i_rr(8'h20,8'h12),                    1'b0, 64'h302,    64'h302,   2'd0, 4'hA, 4'h0, 4'h3, 4'hF, 64'd0,                   64'h302});
        vecs.push_back('{1'b0,1'b0,1'b1,1'b1, 4'd0, 1'b0, 64'h0,     4'd0, 64'h0,      i_rr(8'hB0,8'h4F),                    1'b0, 64'h302,    64'h304,   2'd0, 4'hA, 4'h0, 4'h3, 4'hF, 64'd0,                   64'h302});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b1, 4'd0, 1'b0, 64'h0,     4'd0, 64'h0,      i_1(8'h10),                           1'b0, 64'h304,    64'h305,   2'd0, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0,                   64'd0});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0, 4'd0, 1'b0, 64'h0,     4'd0, 64'h0,      i_rv(8'h30,8'hF3,64'd8),              1'b1, 64'h305,    64'h306,   2'd2, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0,                   64'h306});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0, 4'd0, 1'b0, 64'h0,     4'd0, 64'h0,      i_1(8'hC0),                           1'b0, 64'h306,    64'h307,   2'd3, 4'hC, 4'h0, 4'hF, 4'hF, 64'd0,                   64'h307});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0, 4'd0, 1'b0, 64'h0,     4'd0, 64'h0,      i_1(8'h00),                           1'b0, 64'h307,    64'h308,   2'd1, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0,                   64'h308});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0, 4'd0, 1'b0, 64'h0,     4'd0, 64'h0,      i_1(8'hF1),                           1'b0, 64'h308,    64'h309,   2'd3, 4'hF, 4'h1, 4'hF, 4'hF, 64'd0,                   64'h309});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0, 4'd0, 1'b0, 64'h0,     4'd9, 64'hFFFFFFFFFFFFFFFE, i_rv(8'h30,8'hF5,64'hAB),   1'b0, 64'hFFFFFFFFFFFFFFFE, 64'd8, 2'd0, 4'h3, 4'h0, 4'hF, 4'h5, 64'hAB,              64'd8});
        vecs.push_back('{1'b1,1'b1,1'b1,1'b0, 4'd0, 1'b0, 64'h0,     4'd0, 64'h0,      i_1(8'h10),                           1'b0, 64'd8,      64'd0,     2'd0, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0,                   64'd0});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0, 4'd0, 1'b0, 64'h0,     4'd0, 64'h0,      i_1(8'h10),                           1'b0, 64'h0,      64'd1,     2'd0, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0,                   64'd1});

        // Reset with a pending misprediction: registers clear, f_pc still follows M_valA.
        rst            = 1'b1;
        bus.F_stall    = 1'b0;
        bus.D_stall    = 1'b0;
        bus.D_bubble   = 1'b0;
        bus.M_icode    = 4'd7;
        bus.M_cnd      = 1'b0;
        bus.M_valA     = 64'h55;
        bus.W_icode    = 4'd0;
        bus.W_valM     = 64'h0;
        bus.imem_instr = i_1(8'h10);
        bus.imem_error = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset f_pc", -1, bus.f_pc, 64'h55);
        chk("reset F_predPC", -1, bus.F_predPC, 64'h0);
        chk_d(-1, 2'd0, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst            = vecs[i].rst;
            bus.F_stall    = vecs[i].fs;
            bus.D_stall    = vecs[i].ds;
            bus.D_bubble   = vecs[i].db;
            bus.M_icode    = vecs[i].m_icode;
            bus.M_cnd      = vecs[i].m_cnd;
            bus.M_valA     = vecs[i].m_vala;
            bus.W_icode    = vecs[i].w_icode;
            bus.W_valM     = vecs[i].w_valm;
            bus.imem_instr = vecs[i].instr;
            bus.imem_error = vecs[i].err;
            #2;
            chk("f_pc", i, bus.f_pc, vecs[i].e_fpc);
            @(posedge clk);
            #1;
            chk("F_predPC", i, bus.F_predPC, vecs[i].e_pred);
            chk_d(i, vecs[i].e_stat, vecs[i].e_icode, vecs[i].e_ifun, vecs[i].e_ra, vecs[i].e_rb,
                  vecs[i].e_valc, vecs[i].e_valp);
        end

        // Bubble held under stall, then released: the held bubble must persist
        // for exactly the stalled cycle and the next fetch lands one edge later.
        rst            = 1'b0;
        bus.F_stall    = 1'b1;
        bus.D_stall    = 1'b0;
        bus.D_bubble   = 1'b1;
        bus.M_icode    = 4'd0;
        bus.W_icode    = 4'd0;
        bus.imem_instr = i_v(8'h80, 64'h40);
        bus.imem_error = 1'b0;
        @(posedge clk);
        #1;
        chk("seq bubble F_predPC", 100, bus.F_predPC, 64'd1);
        chk("seq bubble D_icode", 100, {60'd0, bus.D_icode}, 64'd1);
        bus.F_stall  = 1'b0;
        bus.D_bubble = 1'b0;
        #1;
        chk("seq f_pc", 101, bus.f_pc, 64'd1);
        @(posedge clk);
        #1;
        chk("seq F_predPC", 101, bus.F_predPC, 64'h40);
        chk_d(101, 2'd0, 4'h8, 4'h0, 4'hF, 4'hF, 64'h40, 64'hA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
